// File: rtl/blit_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// blit_scheduler_pkg
// Shared blitter header: operation encodings, display geometry constants,
// scheduler state encoding, the queued command layout and the coordinate
// normalisation helper used at enqueue time.
// -----------------------------------------------------------------------------
package blit_scheduler_pkg;

  // Blit operation codes (3-bit field shared with the CPU and the blitter)
  localparam logic [2:0] BLIT_OP_NOP    = 3'd0;
  localparam logic [2:0] BLIT_OP_CLEAR  = 3'd1;
  localparam logic [2:0] BLIT_OP_SPRITE = 3'd2;
  localparam logic [2:0] BLIT_OP_SCROLL = 3'd3;
  localparam logic [2:0] BLIT_OP_FILL   = 3'd4;

  // Display geometry in pixels / lines
  localparam int LORES_W = 64;
  localparam int LORES_H = 32;
  localparam int HIRES_W = 128;
  localparam int HIRES_H = 64;

  localparam int BLT_X_W = 7;
  localparam int BLT_Y_W = 6;

  // SYNC_SETTLE is the extra cycle after the blitter reports ready,
  // giving it time to fall back into its waiting state.
  typedef enum logic [2:0] {
    ST_SYNC,
    ST_SYNC_SETTLE,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_RELEASE
  } sched_state_e;

  // Command as held in the queue, coordinates already normalised
  typedef struct packed {
    logic [2:0]         op;
    logic               hires;
    logic [11:0]        src;
    logic [3:0]         height;
    logic [BLT_X_W-1:0] x;
    logic [BLT_Y_W-1:0] y;
  } blit_cmd_t;

  // Wrap raw CPU coordinates into the visible area of the selected mode.
  function automatic blit_cmd_t normalise_cmd(input logic [2:0]  op,
                                              input logic        hires,
                                              input logic [11:0] src,
                                              input logic [3:0]  height,
                                              input logic [7:0]  x,
                                              input logic [7:0]  y);
    blit_cmd_t c;
    c.op     = op;
    c.hires  = hires;
    c.src    = src;
    c.height = height;
    c.x      = hires ? BLT_X_W'(x % HIRES_W) : BLT_X_W'(x % LORES_W);
    c.y      = hires ? BLT_Y_W'(y % HIRES_H) : BLT_Y_W'(y % LORES_H);
    return c;
  endfunction

endpackage

// File: rtl/blit_cmd_fifo.sv
// -----------------------------------------------------------------------------
// blit_cmd_fifo
// Synchronous FIFO holding queued blit commands.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset (empties the queue)
//   push_i        write data_i (accepted when not full, or full with a pop)
//   data_i        payload in
//   pop_i         remove head entry (ignored when empty)
//   data_o        head entry (valid when !empty_o)
//   full_o        DEPTH entries held
//   empty_o       no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module blit_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A push into a full queue is fine when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/blit_scheduler.sv
// -----------------------------------------------------------------------------
// blit_scheduler
// Command front-end for the framebuffer blitter. Queues CPU blit commands,
// normalises their coordinates, issues them one at a time over the blitter's
// four-phase enable/ready handshake and reports a per-command collision result.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   CPU command queue handshake
//   cmd_op/hires/src/height/x/y   command fields (raw CPU coordinates)
//   blt_operation/hires/src/height/x/y   registered command to the blitter
//   blt_enable / blt_ready   four-phase handshake with the blitter
//   blt_collision         collision flag from the blitter at completion
//   vblank                vertical blank level (optional feature only)
//   res_valid             one-cycle pulse per retired command
//   res_collision         collision of the retired command
//   busy                  queue non-empty or a command in flight
// Optional feature macro: BLIT_VBLANK_SYNC_EN -- when defined, SPRITE commands
// are only popped from the queue while vblank is high.
// -----------------------------------------------------------------------------
module blit_scheduler
  import blit_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic         cmd_hires,
  input  logic [11:0]  cmd_src,
  input  logic [3:0]   cmd_height,
  input  logic [7:0]   cmd_x,
  input  logic [7:0]   cmd_y,
  output logic [2:0]   blt_operation,
  output logic         blt_hires,
  output logic [11:0]  blt_src,
  output logic [3:0]   blt_height,
  output logic [6:0]   blt_x,
  output logic [5:0]   blt_y,
  output logic         blt_enable,
  input  logic         blt_ready,
  input  logic         blt_collision,
  input  logic         vblank,
  output logic         res_valid,
  output logic         res_collision,
  output logic         busy
);

  localparam int CMD_W = $bits(blit_cmd_t);

  sched_state_e state_q, state_d;
  blit_cmd_t    cmd_q, cmd_d;
  logic         enable_q, enable_d;
  logic         res_valid_q, res_valid_d;
  logic         res_coll_q, res_coll_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_wdata, fifo_rdata;
  blit_cmd_t        head;
  logic             head_ok;
  logic             in_sync;

  // ---------------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------------
  assign in_sync    = (state_q == ST_SYNC) || (state_q == ST_SYNC_SETTLE);
  assign cmd_ready  = !fifo_full && !in_sync;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wdata = normalise_cmd(cmd_op, cmd_hires, cmd_src, cmd_height,
                                    cmd_x, cmd_y);
  assign head       = fifo_rdata;

  blit_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef BLIT_VBLANK_SYNC_EN
  // Sprites only start during vertical blank; other ops go straight through.
  assign head_ok = !fifo_empty && ((head.op != BLIT_OP_SPRITE) || vblank);
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign head_ok = !fifo_empty;
`endif

  // ---------------------------------------------------------------------------
  // Scheduler FSM: next state and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    enable_d    = enable_q;
    res_valid_d = 1'b0;
    res_coll_d  = 1'b0;
    fifo_pop    = 1'b0;

    unique case (state_q)
      // The blitter has no reset: wait until it is idle and ready before
      // letting any command through.
      ST_SYNC: begin
        if (blt_ready && !enable_q) state_d = ST_SYNC_SETTLE;
      end
      ST_SYNC_SETTLE: state_d = ST_IDLE;
      ST_IDLE: begin
        if (head_ok) begin
          fifo_pop = 1'b1;
          cmd_d    = head;
          // A zero-row sprite draws nothing, so it retires without issuing.
          if (head.op == BLIT_OP_SPRITE && head.height == 4'd0) begin
            res_valid_d = 1'b1;
          end else begin
            enable_d = 1'b1;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT_START;
      // blt_ready is still high from the blitter's waiting state here.
      ST_WAIT_START: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (blt_ready) begin
          res_valid_d = 1'b1;
          res_coll_d  = (cmd_q.op == BLIT_OP_SPRITE) && blt_collision;
          enable_d    = 1'b0;
          state_d     = ST_RELEASE;
        end
      end
      // One cycle with enable low so the blitter returns to waiting.
      ST_RELEASE: state_d = ST_IDLE;
      default: begin
        enable_d = 1'b0;
        state_d  = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_SYNC;
      cmd_q       <= '0;
      enable_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_coll_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      enable_q    <= enable_d;
      res_valid_q <= res_valid_d;
      res_coll_q  <= res_coll_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign blt_operation = cmd_q.op;
  assign blt_hires     = cmd_q.hires;
  assign blt_src       = cmd_q.src;
  assign blt_height    = cmd_q.height;
  assign blt_x         = cmd_q.x;
  assign blt_y         = cmd_q.y;
  assign blt_enable    = enable_q;
  assign res_valid     = res_valid_q;
  assign res_collision = res_coll_q;
  assign busy          = !(in_sync || state_q == ST_IDLE) || !fifo_empty;

endmodule
